// File: rtl/lives_manager.sv
// Lives tracker for one player: miss/bonus edge detection, saturating bonus lives,
// a post-miss grace window, a one-cycle life-lost pulse and a sticky game-over state.
module lives_manager #(
    parameter int LIVES_W       = 4,
    parameter int MAX_LIVES     = 15,
    parameter int DEFAULT_LIVES = 3,
    parameter int GRACE_CYC     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lives_set,
    input  logic [LIVES_W-1:0] lives_inp,
    input  logic               miss_inp,
    input  logic               bonus_inp,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               grace_active,
    output logic               life_lost
);

    localparam int GCW = (GRACE_CYC > 0) ? (($clog2(GRACE_CYC + 1) > 1) ? $clog2(GRACE_CYC + 1) : 1) : 1;

    localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] DEF_L      = LIVES_W'(DEFAULT_LIVES);
    localparam logic [LIVES_W-1:0] ONE_L      = LIVES_W'(1);
    localparam logic [GCW-1:0]     GRACE_LOAD = GCW'(GRACE_CYC);
    localparam logic [GCW-1:0]     ONE_G      = GCW'(1);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_GRACE = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam state_t RST_STATE = (DEFAULT_LIVES == 0) ? ST_OVER : ST_PLAY;
    localparam logic   RST_OVER  = (DEFAULT_LIVES == 0) ? 1'b1 : 1'b0;

    generate
        if ((MAX_LIVES < 1) || (MAX_LIVES > ((1 << LIVES_W) - 1)) ||
            (DEFAULT_LIVES < 0) || (DEFAULT_LIVES > MAX_LIVES) || (GRACE_CYC < 0)) begin : g_bad_params
            $error("lives_manager: illegal parameter combination");
        end
    endgenerate

    // Loaded values above the ceiling are clipped rather than wrapped.
    function automatic logic [LIVES_W-1:0] clamp_load(input logic [LIVES_W-1:0] v);
        logic [LIVES_W-1:0] r;
        if (v > MAX_L) begin
            r = MAX_L;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Ceiling is checked before adding so the count can never wrap.
    function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v);
        logic [LIVES_W-1:0] r;
        if (v >= MAX_L) begin
            r = MAX_L;
        end else begin
            r = v + ONE_L;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [GCW-1:0]     grace_cnt_q, grace_cnt_d;
    logic               miss_q, bonus_q;
    logic               game_over_q, grace_active_q, life_lost_q, life_lost_d;
    logic               miss_ev_s, bonus_ev_s;

    // Next-state, next-count and pulse computation.
    always_comb begin
        miss_ev_s   = miss_inp & ~miss_q;
        bonus_ev_s  = bonus_inp & ~bonus_q;
        state_d     = state_q;
        lives_d     = lives_q;
        grace_cnt_d = grace_cnt_q;
        life_lost_d = 1'b0;
        if (lives_set) begin
            lives_d     = clamp_load(lives_inp);
            grace_cnt_d = '0;
            if (lives_d == '0) begin
                state_d = ST_OVER;
            end else begin
                state_d = ST_PLAY;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (miss_ev_s && !bonus_ev_s) begin
                        lives_d     = lives_q - ONE_L;
                        life_lost_d = 1'b1;
                        if (lives_d == '0) begin
                            state_d = ST_OVER;
                        end else if (GRACE_CYC > 0) begin
                            grace_cnt_d = GRACE_LOAD;
                            state_d     = ST_GRACE;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else if (bonus_ev_s && !miss_ev_s) begin
                        lives_d = sat_inc(lives_q);
                    end else begin
                        lives_d = lives_q;
                    end
                end
                ST_GRACE: begin
                    // Misses are dropped here, not queued for later.
                    if (bonus_ev_s) begin
                        lives_d = sat_inc(lives_q);
                    end else begin
                        lives_d = lives_q;
                    end
                    if (grace_cnt_q <= ONE_G) begin
                        grace_cnt_d = '0;
                        state_d     = ST_PLAY;
                    end else begin
                        grace_cnt_d = grace_cnt_q - ONE_G;
                        state_d     = ST_GRACE;
                    end
                end
                ST_OVER: begin
                    lives_d     = '0;
                    grace_cnt_d = '0;
                    state_d     = ST_OVER;
                end
                default: begin
                    lives_d     = DEF_L;
                    grace_cnt_d = '0;
                    state_d     = RST_STATE;
                end
            endcase
        end
    end

    // State, count, edge-detect and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RST_STATE;
            lives_q        <= DEF_L;
            grace_cnt_q    <= '0;
            miss_q         <= 1'b0;
            bonus_q        <= 1'b0;
            game_over_q    <= RST_OVER;
            grace_active_q <= 1'b0;
            life_lost_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            grace_cnt_q    <= grace_cnt_d;
            miss_q         <= miss_inp;
            bonus_q        <= bonus_inp;
            game_over_q    <= (state_d == ST_OVER);
            grace_active_q <= (state_d == ST_GRACE);
            life_lost_q    <= life_lost_d;
        end
    end

    assign lives        = lives_q;
    assign game_over    = game_over_q;
    assign grace_active = grace_active_q;
    assign life_lost    = life_lost_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: default-parameter instance plus a GRACE_CYC=0 instance.
module tb_lives_manager;

    logic       clk;
    logic       rst;
    logic       lives_set, miss_inp, bonus_inp;
    logic [3:0] lives_inp;
    logic [3:0] lives;
    logic       game_over, grace_active, life_lost;

    logic       g0_set, g0_miss, g0_bonus;
    logic [3:0] g0_inp;
    logic [3:0] g0_lives;
    logic       g0_go, g0_ga, g0_ll;

    int n_vec = 0;
    int n_err = 0;

    lives_manager dut (
        .clk(clk), .rst(rst), .lives_set(lives_set), .lives_inp(lives_inp),
        .miss_inp(miss_inp), .bonus_inp(bonus_inp), .lives(lives),
        .game_over(game_over), .grace_active(grace_active), .life_lost(life_lost)
    );

    lives_manager #(.GRACE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .lives_set(g0_set), .lives_inp(g0_inp),
        .miss_inp(g0_miss), .bonus_inp(g0_bonus), .lives(g0_lives),
        .game_over(g0_go), .grace_active(g0_ga), .life_lost(g0_ll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (lives !== 4'd3) begin n_err++; $display("FAIL reset_lives: got %0d want 3", lives); end
        n_vec++; if ({game_over, grace_active, life_lost} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {game_over, grace_active, life_lost}); end
        tick; tick;
        rst = 1'b1;
        tick;
        n_vec++; if (lives !== 4'd3 || game_over !== 1'b0) begin n_err++; $display("FAIL reset_release: lives %0d go %b want 3/0", lives, game_over); end
    endtask

    task automatic test_miss_sequence;
        int gcount, llcount;
        for (int k = 0; k < 3; k++) begin
            miss_inp = 1'b1;
            tick;
            n_vec++; if (lives !== 4'(2 - k) || life_lost !== 1'b1) begin n_err++; $display("FAIL seq_miss%0d: lives %0d ll %b want %0d/1", k, lives, life_lost, 2 - k); end
            n_vec++; if (game_over !== (k == 2) || grace_active !== (k < 2)) begin n_err++; $display("FAIL seq_flags%0d: go %b ga %b", k, game_over, grace_active); end
            miss_inp = 1'b0;
            gcount  = grace_active ? 1 : 0;
            llcount = 0;
            for (int c = 0; c < 19; c++) begin
                tick;
                if (grace_active) gcount++;
                if (life_lost) llcount++;
            end
            n_vec++; if (gcount != ((k < 2) ? 16 : 0)) begin n_err++; $display("FAIL seq_grace_len%0d: got %0d want %0d", k, gcount, (k < 2) ? 16 : 0); end
            n_vec++; if (llcount != 0) begin n_err++; $display("FAIL seq_pulse_width%0d: extra pulses %0d want 0", k, llcount); end
        end
        n_vec++; if (lives !== 4'd0 || game_over !== 1'b1) begin n_err++; $display("FAIL seq_end: lives %0d go %b want 0/1", lives, game_over); end
    endtask

    task automatic test_held_miss;
        int llcount;
        lives_set = 1'b1; lives_inp = 4'd5;
        tick;
        lives_set = 1'b0;
        n_vec++; if (lives !== 4'd5 || game_over !== 1'b0) begin n_err++; $display("FAIL held_load: lives %0d go %b want 5/0", lives, game_over); end
        miss_inp = 1'b1;
        llcount = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (life_lost) llcount++;
        end
        n_vec++; if (llcount != 1) begin n_err++; $display("FAIL held_pulses: got %0d want 1", llcount); end
        n_vec++; if (lives !== 4'd4 || grace_active !== 1'b0) begin n_err++; $display("FAIL held_lives: lives %0d ga %b want 4/0", lives, grace_active); end
        miss_inp = 1'b0;
        tick;
    endtask

    task automatic test_grace_events;
        int gcount, llcount;
        miss_inp = 1'b1;
        tick;
        n_vec++; if (lives !== 4'd3 || life_lost !== 1'b1 || grace_active !== 1'b1) begin n_err++; $display("FAIL grace_entry: lives %0d ll %b ga %b want 3/1/1", lives, life_lost, grace_active); end
        miss_inp = 1'b0;
        gcount = 1;
        llcount = 0;
        for (int t = 2; t <= 20; t++) begin
            if (t == 5) miss_inp = 1'b1;
            if (t == 6) miss_inp = 1'b0;
            if (t == 8) bonus_inp = 1'b1;
            if (t == 9) bonus_inp = 1'b0;
            tick;
            if (grace_active) gcount++;
            if (life_lost) llcount++;
        end
        n_vec++; if (gcount != 16) begin n_err++; $display("FAIL grace_len: got %0d want 16", gcount); end
        n_vec++; if (llcount != 0) begin n_err++; $display("FAIL grace_miss_ignored: pulses %0d want 0", llcount); end
        n_vec++; if (lives !== 4'd4) begin n_err++; $display("FAIL grace_bonus: lives %0d want 4", lives); end
    endtask

    task automatic test_saturation_load;
        lives_set = 1'b1; lives_inp = 4'd15;
        tick;
        lives_set = 1'b0;
        n_vec++; if (lives !== 4'd15) begin n_err++; $display("FAIL sat_load: lives %0d want 15", lives); end
        for (int b = 0; b < 2; b++) begin
            bonus_inp = 1'b1; tick;
            bonus_inp = 1'b0; tick;
        end
        n_vec++; if (lives !== 4'd15 || game_over !== 1'b0) begin n_err++; $display("FAIL sat_bonus: lives %0d go %b want 15/0", lives, game_over); end
        lives_set = 1'b1; lives_inp = 4'd0;
        tick;
        lives_set = 1'b0;
        n_vec++; if (lives !== 4'd0 || game_over !== 1'b1 || grace_active !== 1'b0) begin n_err++; $display("FAIL load_zero: lives %0d go %b ga %b want 0/1/0", lives, game_over, grace_active); end
    endtask

    task automatic test_over_and_simul;
        int llcount = 0;
        miss_inp = 1'b1; tick; if (life_lost) llcount++;
        miss_inp = 1'b0; tick; if (life_lost) llcount++;
        bonus_inp = 1'b1; tick;
        bonus_inp = 1'b0; tick;
        n_vec++; if (lives !== 4'd0 || game_over !== 1'b1 || llcount != 0) begin n_err++; $display("FAIL over_sticky: lives %0d go %b pulses %0d want 0/1/0", lives, game_over, llcount); end
        lives_set = 1'b1; lives_inp = 4'd5;
        tick;
        lives_set = 1'b0;
        n_vec++; if (lives !== 4'd5 || game_over !== 1'b0 || grace_active !== 1'b0) begin n_err++; $display("FAIL over_exit: lives %0d go %b ga %b want 5/0/0", lives, game_over, grace_active); end
        miss_inp = 1'b1; bonus_inp = 1'b1;
        tick;
        n_vec++; if (lives !== 4'd5 || life_lost !== 1'b0 || grace_active !== 1'b0) begin n_err++; $display("FAIL simul_events: lives %0d ll %b ga %b want 5/0/0", lives, life_lost, grace_active); end
        miss_inp = 1'b0; bonus_inp = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        miss_inp = 1'b1;
        tick;
        n_vec++; if (lives !== 4'd4 || grace_active !== 1'b1) begin n_err++; $display("FAIL arst_pre: lives %0d ga %b want 4/1", lives, grace_active); end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (lives !== 4'd3 || {game_over, grace_active, life_lost} !== 3'b000) begin n_err++; $display("FAIL arst_mid_grace: lives %0d flags %b want 3/000", lives, {game_over, grace_active, life_lost}); end
        tick;
        rst = 1'b1;
        tick;
        n_vec++; if (lives !== 4'd2 || life_lost !== 1'b1) begin n_err++; $display("FAIL first_clock_event: lives %0d ll %b want 2/1", lives, life_lost); end
        miss_inp = 1'b0;
        tick;
    endtask

    task automatic test_no_grace;
        for (int k = 0; k < 3; k++) begin
            g0_miss = 1'b1;
            tick;
            n_vec++; if (g0_lives !== 4'(2 - k) || g0_ll !== 1'b1 || g0_ga !== 1'b0 || g0_go !== (k == 2)) begin n_err++; $display("FAIL nograce_miss%0d: lives %0d ll %b ga %b go %b", k, g0_lives, g0_ll, g0_ga, g0_go); end
            g0_miss = 1'b0;
            tick;
            n_vec++; if (g0_ll !== 1'b0 || g0_ga !== 1'b0) begin n_err++; $display("FAIL nograce_after%0d: ll %b ga %b want 0/0", k, g0_ll, g0_ga); end
        end
    endtask

    initial begin
        lives_set = 1'b0; lives_inp = 4'd0; miss_inp = 1'b0; bonus_inp = 1'b0;
        g0_set = 1'b0; g0_inp = 4'd0; g0_miss = 1'b0; g0_bonus = 1'b0;
        test_reset;
        test_miss_sequence;
        test_held_miss;
        test_grace_events;
        test_saturation_load;
        test_over_and_simul;
        test_async_reset;
        test_no_grace;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
